// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: field positions, NOP encoding, load opcode.
package id_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_CNT = 32;
  localparam int AW      = 5;

  localparam logic [5:0]  OP_LOAD  = 6'b100011;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/id_stage_reg_file.sv
// 2-read/1-write register file, r0 hardwired to zero; reads are combinational.
// A write in flight is forwarded to a matching read port in the same cycle.
module id_stage_reg_file
  import id_stage_pkg::*;
#(
  parameter int DATA_W  = id_stage_pkg::DATA_W,
  parameter int REG_CNT = id_stage_pkg::REG_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [REG_CNT];
  logic              wr_hit;

  assign wr_hit = we && (waddr != REG_ZERO);

  // Reset takes priority so a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == REG_ZERO)
      rdata_a = '0;
    else if (wr_hit && (waddr == raddr_a))
      rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == REG_ZERO)
      rdata_b = '0;
    else if (wr_hit && (waddr == raddr_b))
      rdata_b = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, field split, register read, load-use hazard detect.
// One cycle from fetch to decode outputs; stall_out holds fetch and IF/ID, flush squashes to a bubble.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W  = id_stage_pkg::DATA_W,
  parameter int REG_CNT = id_stage_pkg::REG_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic              flush_in,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              valid_out,
  output logic [31:0]       pc_out,
  output logic [5:0]        opcode_out,
  output logic [4:0]        rs_out,
  output logic [4:0]        rt_out,
  output logic [4:0]        rd_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;

  // Flush beats stall so a squashed slot never keeps a stale instruction alive.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_in) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (!stall_out) begin
      instr_q <= instr_in;
      pc_q    <= pc_in;
      valid_q <= 1'b1;
    end
  end

  assign pc_out     = pc_q;
  assign opcode_out = instr_q[OP_HI:OP_LO];
  assign rs_out     = instr_q[RS_HI:RS_LO];
  assign rt_out     = instr_q[RT_HI:RT_LO];
  assign rd_out     = instr_q[RD_HI:RD_LO];
  assign imm_out    = {{(DATA_W-16){instr_q[IMM_HI]}}, instr_q[IMM_HI:IMM_LO]};

  assign stall_out = valid_q && ex_mem_read && (ex_rt != REG_ZERO) &&
                     ((ex_rt == rs_out) || (ex_rt == rt_out));
  assign valid_out = valid_q && !stall_out;

  id_stage_reg_file #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_out),
    .raddr_b (rt_out),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: stimulus pushes expected decode snapshots, a negedge monitor pops and compares.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, pc_in;
  logic        flush_in, ex_mem_read;
  logic [4:0]  ex_rt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall_out, valid_out;
  logic [31:0] pc_out;
  logic [5:0]  opcode_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic [31:0] imm_out, rs_data, rt_data;

  id_stage dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .flush_in(flush_in),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall_out(stall_out), .valid_out(valid_out), .pc_out(pc_out),
    .opcode_out(opcode_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .imm_out(imm_out), .rs_data(rs_data), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        vld;
    logic        stl;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rsd;
    logic [31:0] rtd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, fld, act, req);
    end
  endtask

  task automatic expect_out(input string name, input logic vld, input logic stl, input logic [31:0] pc,
                            input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] imm,
                            input logic [31:0] rsd, input logic [31:0] rtd);
    exp_t e;
    e.name = name; e.vld = vld; e.stl = stl; e.pc = pc; e.op = op; e.rs = rs;
    e.rt = rt; e.rd = rd; e.imm = imm; e.rsd = rsd; e.rtd = rtd;
    sb.push_back(e);
  endtask

  // Monitor: decode outputs are live every cycle, so each pending snapshot is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "valid", {31'd0, valid_out}, {31'd0, e.vld});
      chk(e.name, "stall", {31'd0, stall_out}, {31'd0, e.stl});
      chk(e.name, "pc",    pc_out,             e.pc);
      chk(e.name, "op",    {26'd0, opcode_out}, {26'd0, e.op});
      chk(e.name, "rs",    {27'd0, rs_out},    {27'd0, e.rs});
      chk(e.name, "rt",    {27'd0, rt_out},    {27'd0, e.rt});
      chk(e.name, "rd",    {27'd0, rd_out},    {27'd0, e.rd});
      chk(e.name, "imm",   imm_out,            e.imm);
      chk(e.name, "rs_data", rs_data,          e.rsd);
      chk(e.name, "rt_data", rt_data,          e.rtd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr_in = '0; pc_in = '0; flush_in = 1'b0; ex_mem_read = 1'b0;
    ex_rt = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // A: reset state visible after release; present addi r8,r0,-1 at pc 4
    rst = 1'b0; instr_in = 32'h2008_FFFF; pc_in = 32'd4;
    expect_out("reset", 0, 0, 0, 6'h00, 0, 0, 0, 32'h0, 32'h0, 32'h0);

    // B: decode of 2008_FFFF one cycle later
    cyc(); instr_in = 32'h00A6_3820; pc_in = 32'd8;
    expect_out("signext", 1, 0, 32'd4, 6'h08, 5'd0, 5'd8, 5'd31, 32'hFFFF_FFFF, 32'h0, 32'h0);

    // C: rs=5 decoded while r5 is being written -> bypass
    cyc(); wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    expect_out("bypass", 1, 0, 32'd8, 6'h00, 5'd5, 5'd6, 5'd7, 32'h0000_3820, 32'hDEAD_BEEF, 32'h0);

    // D: same instruction, value now read from the file
    cyc(); wb_we = 1'b0; instr_in = 32'h0000_4020; pc_in = 32'd12;
    expect_out("file_read", 1, 0, 32'd8, 6'h00, 5'd5, 5'd6, 5'd7, 32'h0000_3820, 32'hDEAD_BEEF, 32'h0);

    // E: write to r0 while rs=rt=0 is decoded: no bypass
    cyc(); wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234;
    expect_out("r0_nobyp", 1, 0, 32'd12, 6'h00, 5'd0, 5'd0, 5'd8, 32'h0000_4020, 32'h0, 32'h0);

    // F: r0 still reads zero afterwards
    cyc(); wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; instr_in = 32'h2028_0003; pc_in = 32'd16;
    expect_out("r0_zero", 1, 0, 32'd12, 6'h00, 5'd0, 5'd0, 5'd8, 32'h0000_4020, 32'h0, 32'h0);

    // G: load in EX targets rt=8 -> stall, bubble
    cyc(); ex_mem_read = 1'b1; ex_rt = 5'd8; instr_in = 32'h2129_0002; pc_in = 32'd20;
    expect_out("stall", 0, 1, 32'd16, 6'h08, 5'd1, 5'd8, 5'd0, 32'h3, 32'h0, 32'h0);

    // H: stall persists, pc held
    cyc();
    expect_out("stall_hold", 0, 1, 32'd16, 6'h08, 5'd1, 5'd8, 5'd0, 32'h3, 32'h0, 32'h0);

    // I: load leaves EX -> same instruction re-presents as valid
    cyc(); ex_mem_read = 1'b0; ex_rt = 5'd0;
    expect_out("unstall", 1, 0, 32'd16, 6'h08, 5'd1, 5'd8, 5'd0, 32'h3, 32'h0, 32'h0);

    // J: stall on rs/rt=9 together with flush
    cyc(); ex_mem_read = 1'b1; ex_rt = 5'd9; flush_in = 1'b1; instr_in = 32'h2008_0001; pc_in = 32'd24;
    expect_out("stall_flush", 0, 1, 32'd20, 6'h08, 5'd9, 5'd9, 5'd0, 32'h2, 32'h0, 32'h0);

    // K: flush wins, bubble with pc unchanged; stall clears; flush again outside a stall
    cyc(); flush_in = 1'b1;
    expect_out("flushed", 0, 0, 32'd20, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    // L: plain flush of 2008_0001 yields bubble
    cyc(); flush_in = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    expect_out("flush2", 0, 0, 32'd20, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    // M: 2008_0001 decoded; write r8 with bypass to rt
    cyc(); wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hCAFE_0008;
    expect_out("byp_rt", 1, 0, 32'd24, 6'h08, 5'd0, 5'd8, 5'd0, 32'h1, 32'h0, 32'hCAFE_0008);

    // N: r8 from file; reset asserted with a concurrent write to r9
    cyc(); rst = 1'b1; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h5555_5555;
    instr_in = 32'h2128_0000; pc_in = 32'd28;
    expect_out("pre_rst", 1, 0, 32'd24, 6'h08, 5'd0, 5'd8, 5'd0, 32'h1, 32'h0, 32'hCAFE_0008);

    // O: everything back to reset values
    cyc(); rst = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    expect_out("mid_rst", 0, 0, 32'd0, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    // P: r9 write was dropped and r8 was cleared
    cyc();
    expect_out("rst_clear", 1, 0, 32'd28, 6'h08, 5'd9, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d snapshots unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: bench did not complete within 5000 time units");
    $fatal(1);
  end

endmodule
